// File: rtl/sprite_cmd_pkg.sv
// Shared definitions for the sprite command encoder: command field codes,
// the object table entry layout, the emission FSM state type and a helper
// that assembles a 32-bit display command word.
package sprite_cmd_pkg;

   localparam logic [3:0] INFO_NOP   = 4'b0000;
   localparam logic [3:0] INFO_WRITE = 4'b0001;
   localparam logic [3:0] INFO_FLUSH = 4'b1111;

   localparam logic [2:0] TYPE_ATTR  = 3'b001;
   localparam logic [2:0] TYPE_X     = 3'b010;
   localparam logic [2:0] TYPE_Y     = 3'b011;
   localparam logic [2:0] TYPE_SHIFT = 3'b100;

   typedef struct packed {
      logic       visible;
      logic       flip;
      logic [4:0] pattern;
      logic [9:0] x;
      logic [9:0] y;
      logic [9:0] shift;
   } obj_entry_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_ATTR,
      ST_X,
      ST_Y,
      ST_SHIFT,
      ST_FLUSH,
      ST_DONE
   } state_t;

   // Word layout: sub-component, child, info, type, ping-pong select, message.
   function automatic logic [31:0] pack_cmd(input logic [5:0]  sub,
                                            input logic [4:0]  child,
                                            input logic [3:0]  info,
                                            input logic [2:0]  typ,
                                            input logic        pp,
                                            input logic [12:0] msg);
      return {sub, child, info, typ, pp, msg};
   endfunction

endpackage

// File: rtl/sprite_cmd_encoder_if.sv
// Command word bus between the encoder and the display peripherals.
//   writedata : 32-bit command word
//   cmd_valid : writedata carries a live command
//   cmd_ready : downstream accepts the current word this cycle
interface sprite_cmd_encoder_if;
   logic [31:0] writedata;
   logic        cmd_valid;
   logic        cmd_ready;

   modport master (output writedata, output cmd_valid, input cmd_ready);
   modport slave  (input writedata, input cmd_valid, output cmd_ready);
endinterface

// File: rtl/sprite_obj_table.sv
// Host-writable object table plus a shadow copy used for frame emission.
//   clk, reset          : clock, synchronous active-high reset
//   obj_we, obj_idx     : write strobe and target entry
//   wr_entry            : entry contents to write
//   snap                : copy the live table into the shadow this edge
//   rd_idx, rd_entry    : combinational read of the shadow table
//   obj_err             : one-cycle pulse when a write is rejected
module sprite_obj_table
   import sprite_cmd_pkg::*;
#(
   parameter int NUM_OBJ     = 9,
   parameter int PATTERN_NUM = 17
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       obj_we,
   input  logic [4:0] obj_idx,
   input  obj_entry_t wr_entry,
   input  logic       snap,
   input  logic [4:0] rd_idx,
   output obj_entry_t rd_entry,
   output logic       obj_err
);

   obj_entry_t live   [NUM_OBJ];
   obj_entry_t shadow [NUM_OBJ];
   logic       wr_ok;

   assign wr_ok = obj_we && (int'(obj_idx) < NUM_OBJ)
                         && (int'(wr_entry.pattern) < PATTERN_NUM);

   // The snapshot copies the live table as it stood before this edge, so a
   // write landing on the same edge only shows up in the following frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_OBJ; i++) begin
            live[i]   <= '0;
            shadow[i] <= '0;
         end
         obj_err <= 1'b0;
      end else begin
         obj_err <= obj_we && !wr_ok;
         for (int i = 0; i < NUM_OBJ; i++) begin
            if (wr_ok && int'(obj_idx) == i)
               live[i] <= wr_entry;
            if (snap)
               shadow[i] <= live[i];
         end
      end
   end

   // Out-of-range indices read as an empty entry.
   always_comb begin
      rd_entry = '0;
      for (int i = 0; i < NUM_OBJ; i++) begin
         if (int'(rd_idx) == i)
            rd_entry = shadow[i];
      end
   end

endmodule

// File: rtl/sprite_cmd_encoder.sv
// Serialises the sprite object table into display command words once per
// frame_start, targeting the back buffer, and ends with a flush word that
// swaps the display's front buffer.
//   clk, reset       : clock, synchronous active-high reset
//   frame_start      : vsync pulse starting a frame emission
//   obj_*            : object table write port
//   cmd              : command word bus (writedata/cmd_valid/cmd_ready)
//   busy             : frame emission in progress
//   frame_done       : one-cycle pulse after the flush word is accepted
//   front_sel        : buffer currently displayed
//   overrun          : sticky, frame_start arrived while busy
//   obj_err          : one-cycle pulse, table write rejected
module sprite_cmd_encoder
   import sprite_cmd_pkg::*;
#(
   parameter logic [5:0] SUB_COMP_ID = 6'b000010,
   parameter int         NUM_OBJ     = 9,
   parameter int         PATTERN_NUM = 17
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        frame_start,
   input  logic                        obj_we,
   input  logic [4:0]                  obj_idx,
   input  logic                        obj_visible,
   input  logic                        obj_flip,
   input  logic [4:0]                  obj_pattern,
   input  logic [9:0]                  obj_x,
   input  logic [9:0]                  obj_y,
   input  logic [9:0]                  obj_shift,
   sprite_cmd_encoder_if.master        cmd,
   output logic                        busy,
   output logic                        frame_done,
   output logic                        front_sel,
   output logic                        overrun,
   output logic                        obj_err
);

   state_t      state_q, state_n;
   logic [4:0]  child_q, child_n;
   logic        back_q, back_n;
   obj_entry_t  cur_q, cur_n;
   logic [31:0] wd_q, wd_n;
   logic        valid_q, valid_n;
   logic        busy_n, done_n, front_n, overrun_n;
   logic        snap;
   logic        last;
   logic [4:0]  rd_idx;
   obj_entry_t  rd_entry;
   obj_entry_t  wr_entry;
   logic [31:0] next_attr_word;
   logic [31:0] flush_word;

   function automatic logic [12:0] attr_msg(input obj_entry_t e);
      return {e.visible, e.flip, 6'b0, e.pattern};
   endfunction

   assign wr_entry = '{visible: obj_visible, flip: obj_flip, pattern: obj_pattern,
                       x: obj_x, y: obj_y, shift: obj_shift};

   sprite_obj_table #(
      .NUM_OBJ     (NUM_OBJ),
      .PATTERN_NUM (PATTERN_NUM)
   ) u_table (
      .clk      (clk),
      .reset    (reset),
      .obj_we   (obj_we),
      .obj_idx  (obj_idx),
      .wr_entry (wr_entry),
      .snap     (snap),
      .rd_idx   (rd_idx),
      .rd_entry (rd_entry),
      .obj_err  (obj_err)
   );

   // The shadow read port prefetches the object after the current one (or
   // object 0 during LOAD), so the next ATTR word is ready when it is needed
   // without a combinational path from the next-state logic back into it.
   assign rd_idx         = child_q + {4'b0, (state_q != ST_LOAD)};
   assign last           = (child_q == 5'(NUM_OBJ - 1));
   assign next_attr_word = pack_cmd(SUB_COMP_ID, child_q + 5'd1, INFO_WRITE, TYPE_ATTR,
                                    back_q, attr_msg(rd_entry));
   assign flush_word     = pack_cmd(SUB_COMP_ID, 5'd0, INFO_FLUSH, 3'b000, back_q, 13'd0);

   assign cmd.writedata = wd_q;
   assign cmd.cmd_valid = valid_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         child_q    <= '0;
         back_q     <= 1'b0;
         cur_q      <= '0;
         wd_q       <= '0;
         valid_q    <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         front_sel  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         state_q    <= state_n;
         child_q    <= child_n;
         back_q     <= back_n;
         cur_q      <= cur_n;
         wd_q       <= wd_n;
         valid_q    <= valid_n;
         busy       <= busy_n;
         frame_done <= done_n;
         front_sel  <= front_n;
         overrun    <= overrun_n;
      end
   end

   // Next-state and next-output logic. Outputs are registered, so each
   // branch prepares the word that will be on the bus in the next state;
   // when cmd_ready is low the defaults hold the current word unchanged.
   always_comb begin
      state_n   = state_q;
      child_n   = child_q;
      back_n    = back_q;
      cur_n     = cur_q;
      wd_n      = wd_q;
      valid_n   = valid_q;
      busy_n    = busy;
      done_n    = 1'b0;
      front_n   = front_sel;
      overrun_n = overrun;
      snap      = 1'b0;

      if (frame_start && state_q != ST_IDLE)
         overrun_n = 1'b1;

      unique case (state_q)
         ST_IDLE: begin
            if (frame_start) begin
               state_n = ST_LOAD;
               snap    = 1'b1;
               child_n = 5'd0;
               busy_n  = 1'b1;
            end
         end
         ST_LOAD: begin
            back_n  = ~front_sel;
            cur_n   = rd_entry;
            wd_n    = pack_cmd(SUB_COMP_ID, 5'd0, INFO_WRITE, TYPE_ATTR, ~front_sel,
                               attr_msg(rd_entry));
            valid_n = 1'b1;
            state_n = ST_ATTR;
         end
         ST_ATTR: begin
            if (cmd.cmd_ready) begin
               if (cur_q.visible) begin
                  state_n = ST_X;
                  wd_n    = pack_cmd(SUB_COMP_ID, child_q, INFO_WRITE, TYPE_X, back_q,
                                     {3'b0, cur_q.x});
               end else if (last) begin
                  state_n = ST_FLUSH;
                  wd_n    = flush_word;
               end else begin
                  child_n = child_q + 5'd1;
                  cur_n   = rd_entry;
                  wd_n    = next_attr_word;
               end
            end
         end
         ST_X: begin
            if (cmd.cmd_ready) begin
               state_n = ST_Y;
               wd_n    = pack_cmd(SUB_COMP_ID, child_q, INFO_WRITE, TYPE_Y, back_q,
                                  {3'b0, cur_q.y});
            end
         end
         ST_Y: begin
            if (cmd.cmd_ready) begin
               state_n = ST_SHIFT;
               wd_n    = pack_cmd(SUB_COMP_ID, child_q, INFO_WRITE, TYPE_SHIFT, back_q,
                                  {3'b0, cur_q.shift});
            end
         end
         ST_SHIFT: begin
            if (cmd.cmd_ready) begin
               if (last) begin
                  state_n = ST_FLUSH;
                  wd_n    = flush_word;
               end else begin
                  state_n = ST_ATTR;
                  child_n = child_q + 5'd1;
                  cur_n   = rd_entry;
                  wd_n    = next_attr_word;
               end
            end
         end
         ST_FLUSH: begin
            if (cmd.cmd_ready) begin
               state_n = ST_DONE;
               front_n = back_q;
               done_n  = 1'b1;
               busy_n  = 1'b0;
               valid_n = 1'b0;
               wd_n    = pack_cmd(6'd0, 5'd0, INFO_NOP, 3'b000, 1'b0, 13'd0);
            end
         end
         ST_DONE: begin
            state_n = ST_IDLE;
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

endmodule
